mem_arb: RTL
============

# mem_arb

Two-requester arbiter sharing the single unified main-memory port between the instruction-cache fill path and the data-cache fill/writeback path in `proc_hier`. It accepts one transaction at a time, drives the memory port for one issue cycle, and counts the fixed memory latency. It returns read data, and a one-cycle completion pulse, to the winning requester. Fairness is round-robin on simultaneous requests.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 4, cycles from accepted issue to `mem_data_out` valid (≥2)

- `clk`  in  1  clock
- `rst`  in  1  reset. Asynchronous, active-high.
- `ic_req`  in  1  I-side read request, level, held until `ic_done`
- `ic_addr`  in  ADDR_W  I-side address
- `ic_grant`  out  1  one-cycle pulse when the I-side request is accepted
- `ic_done`  out  1  one-cycle pulse, `ic_data_out` valid
- `ic_data_out`  out  DATA_W  I-side read data, registered
- `dc_req`  in  1  D-side request, level
- `dc_wr`  in  1  1 = write, 0 = read
- `dc_addr`  in  ADDR_W  D-side address
- `dc_data_in`  in  DATA_W  D-side write data
- `dc_grant`, `dc_done`  out  1  as I-side
- `dc_data_out`  out  DATA_W  D-side read data, registered
- `mem_addr`  out  ADDR_W  memory address
- `mem_data_in`  out  DATA_W  memory write data
- `mem_rd`, `mem_wr`  out  1  memory command, asserted in the issue cycle only
- `mem_stall`  in  1  memory cannot accept a command this cycle
- `mem_data_out`  in  DATA_W  memory read data
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- States and transitions:
  - IDLE: on any request → GRANT.
  - GRANT: → ISSUE.
  - ISSUE: stays while `mem_stall`; otherwise → WAIT.
  - WAIT: after MEM_LAT−1 cycles → CAPTURE.
  - CAPTURE: → DONE.
  - DONE: → IDLE.
- Arbitration happens in IDLE only:
  - Only one request high: that requester wins.
  - Both high: the requester that was not `last_winner` wins.
  - `last_winner` resets to IC, so the first tie goes to DC.
- GRANT:
  - Pulse `*_grant` for the winner.
  - Latch the winner id, address, wr and write data. For IC, wr = 0.
  - Update `last_winner`.
- ISSUE:
  - Drive `mem_addr` and `mem_data_in` from the latches.
  - Assert `mem_rd` or `mem_wr` while `mem_stall` = 0; leave the state the same cycle.
  - While `mem_stall` = 1: drive the command, stay in ISSUE, and reissue next cycle.
  - `mem_stall` is ignored outside ISSUE.
- WAIT: the down-counter loads MEM_LAT−1 on issue accept.
- CAPTURE:
  - Read: register `mem_data_out` into the winner's `*_data_out`.
  - Write: `*_data_out` holds its previous value.
- DONE: pulse the winner's `*_done`.
- A request withdrawn before grant has no effect.
- After grant, the transaction completes and `*_done` pulses even if the request drops.
- Requests are sampled only in IDLE. A request still high in DONE is re-arbitrated in the next IDLE cycle.
- `rst` mid-transaction:
  - State → IDLE; the in-flight operation is abandoned.
  - No `*_done` pulse.
  - Memory shares `rst`.
- Reset values:
  - All outputs = 0, including both `*_data_out`.
  - State = IDLE, counter = 0, `last_winner` = IC.

## Timing
- Request seen in IDLE at cycle t:
  - `*_grant` at t+1.
  - Issue accepted at t+2 (plus stall cycles s).
  - `mem_data_out` sampled at t+2+s+MEM_LAT.
  - `*_done` at t+3+s+MEM_LAT.
  - Back in IDLE at t+4+s+MEM_LAT.
- MEM_LAT = 4, no stall: grant t+1, `mem_rd` t+2, done t+7, next arbitration t+8.
- Throughput: one transaction per MEM_LAT+4 cycles.
- `mem_*` outputs are combinational from state and latches. They are 0 outside ISSUE, except `mem_addr`/`mem_data_in`, which hold the latch value.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, GRANT, ISSUE, WAIT, CAPTURE, DONE}
  - requester id constants REQ_IC = 0, REQ_DC = 1
  - default MEM_LAT
- Sub-module `mem_arb_rr`: 2-way round-robin picker. Inputs are the requests and `last_winner`; outputs are winner valid and winner id.
- Top level holds the FSM, latches, latency counter and output registers.

## Test plan
- IC read alone to 0x0040, memory returns 0x1234 → `ic_grant` at t+1, `mem_rd` with `mem_addr`=0x0040 at t+2, `ic_done` with `ic_data_out`=0x1234 at t+7, `dc_*` silent.
- DC write 0xBEEF to 0x0100 → single-cycle `mem_wr` with `mem_data_in`=0xBEEF at t+2, `dc_done` at t+7, `dc_data_out` unchanged.
- Both requests held from reset → order DC, IC, DC, IC; each `*_done` exactly MEM_LAT+4 cycles apart.
- `mem_stall` high for 3 cycles in ISSUE → command held 4 cycles, `mem_rd` counted once accepted, done at t+10.
- `rst` asserted mid-WAIT → next edge shows all outputs 0, `busy`=0, no `*_done`; the following tie goes to DC.
- Request dropped before grant gets no grant; request dropped after grant still gets `*_done`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } arbState_t;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  localparam int DEFAULT_MEM_LAT = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever
// did not win last time.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic icReq,
  input  logic dcReq,
  input  logic lastWinner,
  output logic winValid,
  output logic winId
);

  // Pick the winner from the current requests and the previous winner
  always_comb begin
    winValid = icReq | dcReq;
    winId    = REQ_IC;
    if (icReq && dcReq) begin
      winId = ~lastWinner;
    end else if (dcReq) begin
      winId = REQ_DC;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one main-memory port between the I-cache fill path and the
// D-cache fill/writeback path. One transaction in flight at a time.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_data_out,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_data_in,
  output logic              dc_grant,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arbState_t         state;
  arbState_t         nextState;
  logic              rrValid;
  logic              rrId;
  logic              winIdReg;
  logic              lastWinner;
  logic              latchWr;
  logic [ADDR_W-1:0] latchAddr;
  logic [DATA_W-1:0] latchData;
  logic [CNT_W-1:0]  cnt;

  mem_arb_rr picker (
    .icReq      (ic_req),
    .dcReq      (dc_req),
    .lastWinner (lastWinner),
    .winValid   (rrValid),
    .winId      (rrId)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; the latency counter ends WAIT after MEM_LAT-1 cycles
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (rrValid) nextState = GRANT;
      GRANT:   nextState = ISSUE;
      ISSUE:   if (!mem_stall) nextState = WAIT;
      WAIT:    if (cnt <= CNT_W'(1)) nextState = CAPTURE;
      CAPTURE: nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Capture the winner and its transaction as IDLE hands over to GRANT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winIdReg   <= REQ_IC;
      lastWinner <= REQ_IC;
      latchWr    <= 1'b0;
      latchAddr  <= '0;
      latchData  <= '0;
    end else if (state == IDLE && rrValid) begin
      winIdReg   <= rrId;
      lastWinner <= rrId;
      latchWr    <= (rrId == REQ_DC) && dc_wr;
      latchAddr  <= (rrId == REQ_DC) ? dc_addr : ic_addr;
      latchData  <= (rrId == REQ_DC) ? dc_data_in : '0;
    end
  end

  // Latency down-counter, loaded when memory accepts the command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ISSUE && !mem_stall) begin
      cnt <= LAT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Register read data for the winner; writes leave the old value in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_data_out <= '0;
      dc_data_out <= '0;
    end else if (state == CAPTURE && !latchWr) begin
      if (winIdReg == REQ_DC) begin
        dc_data_out <= mem_data_out;
      end else begin
        ic_data_out <= mem_data_out;
      end
    end
  end

  // Pulses and memory command decoded from state and the latches
  always_comb begin
    ic_grant    = (state == GRANT) && (winIdReg == REQ_IC);
    dc_grant    = (state == GRANT) && (winIdReg == REQ_DC);
    ic_done     = (state == DONE) && (winIdReg == REQ_IC);
    dc_done     = (state == DONE) && (winIdReg == REQ_DC);
    mem_addr    = latchAddr;
    mem_data_in = latchData;
    mem_rd      = (state == ISSUE) && !latchWr;
    mem_wr      = (state == ISSUE) && latchWr;
    busy        = (state != IDLE);
  end

endmodule
